// File: rtl/i2s_pcm_transmitter.sv
// I2S transmitter: serializes one stereo PCM pair per frame onto sck/ws/sd (MSB first,
// one sck after each ws edge). Upstream loads pairs into a one-entry holding register.
// Ports: clk/reset (sync, active-high); enable (run request, sampled at frame boundaries);
//        pcm_left/pcm_right/pcm_valid/pcm_ready (holding-register handshake);
//        sck/ws/sd (registered serial outputs); frame_start/underrun (1-cycle status pulses).
module i2s_pcm_transmitter #(
    parameter int NUMBER_OF_BITS = 12,
    parameter int SLOT_BITS      = 16,
    parameter int CLK_DIV        = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUMBER_OF_BITS-1:0] pcm_left,
    input  logic [NUMBER_OF_BITS-1:0] pcm_right,
    input  logic                      pcm_valid,
    output logic                      pcm_ready,
    output logic                      sck,
    output logic                      ws,
    output logic                      sd,
    output logic                      frame_start,
    output logic                      underrun
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam int SW = (NUMBER_OF_BITS > 1) ? $clog2(NUMBER_OF_BITS) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(SLOT_BITS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state, state_nxt;
    logic [DW-1:0]             div_cnt, div_nxt;
    logic [PW-1:0]             p, p_nxt;
    logic                      sck_nxt, ws_nxt, sd_nxt;
    logic                      ready_nxt, fs_nxt, ur_nxt;
    logic [NUMBER_OF_BITS-1:0] hold_left, hold_right, hold_left_nxt, hold_right_nxt;
    logic [NUMBER_OF_BITS-1:0] tx_left, tx_right, tx_left_nxt, tx_right_nxt;
    logic                      fs_event;

    // Slot bit p carries sample[N-p] for 1..N; slot bit 0 and the tail pad are zero.
    function automatic logic bit_at(input logic [NUMBER_OF_BITS-1:0] s, input logic [PW-1:0] pos);
        int pi;
        pi = int'(pos);
        bit_at = 1'b0;
        if (pi >= 1 && pi <= NUMBER_OF_BITS) begin
            bit_at = s[SW'(NUMBER_OF_BITS - pi)];
        end
    endfunction

    always_comb begin
        state_nxt      = state;
        div_nxt        = div_cnt;
        p_nxt          = p;
        sck_nxt        = sck;
        ws_nxt         = ws;
        sd_nxt         = sd;
        ready_nxt      = pcm_ready;
        fs_nxt         = 1'b0;
        ur_nxt         = 1'b0;
        hold_left_nxt  = hold_left;
        hold_right_nxt = hold_right;
        tx_left_nxt    = tx_left;
        tx_right_nxt   = tx_right;
        fs_event       = 1'b0;

        // pcm_ready doubles as "holding register empty", so an accept can
        // never collide with the load that empties it.
        if (pcm_valid && pcm_ready) begin
            hold_left_nxt  = pcm_left;
            hold_right_nxt = pcm_right;
            ready_nxt      = 1'b0;
        end

        case (state)
            IDLE: begin
                sck_nxt = 1'b0;
                ws_nxt  = 1'b1;
                sd_nxt  = 1'b0;
                div_nxt = '0;
                p_nxt   = '0;
                if (enable) begin
                    fs_event = 1'b1;
                end
            end
            RUN: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    sck_nxt = ~sck;
                    if (sck) begin
                        // Falling edge: advance the bit position, present the next bit.
                        if (p == P_LAST) begin
                            p_nxt  = '0;
                            ws_nxt = ~ws;
                            sd_nxt = 1'b0;
                            if (ws) begin
                                // End of right slot: frame boundary.
                                if (enable) begin
                                    fs_event = 1'b1;
                                end else begin
                                    state_nxt = IDLE;
                                    ws_nxt    = 1'b1;
                                end
                            end
                        end else begin
                            p_nxt  = p + 1'b1;
                            sd_nxt = bit_at(ws ? tx_right : tx_left, p + 1'b1);
                        end
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (fs_event) begin
            state_nxt = RUN;
            ws_nxt    = 1'b0;
            p_nxt     = '0;
            sd_nxt    = 1'b0;
            sck_nxt   = 1'b0;
            div_nxt   = '0;
            fs_nxt    = 1'b1;
            if (!pcm_ready) begin
                tx_left_nxt  = hold_left;
                tx_right_nxt = hold_right;
                ready_nxt    = 1'b1;
            end else begin
                // Nothing held: send silence. A pair accepted this same cycle
                // stays in the holding register for the next frame.
                tx_left_nxt  = '0;
                tx_right_nxt = '0;
                ur_nxt       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            p           <= '0;
            sck         <= 1'b0;
            ws          <= 1'b1;
            sd          <= 1'b0;
            pcm_ready   <= 1'b1;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            hold_left   <= '0;
            hold_right  <= '0;
            tx_left     <= '0;
            tx_right    <= '0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= div_nxt;
            p           <= p_nxt;
            sck         <= sck_nxt;
            ws          <= ws_nxt;
            sd          <= sd_nxt;
            pcm_ready   <= ready_nxt;
            frame_start <= fs_nxt;
            underrun    <= ur_nxt;
            hold_left   <= hold_left_nxt;
            hold_right  <= hold_right_nxt;
            tx_left     <= tx_left_nxt;
            tx_right    <= tx_right_nxt;
        end
    end
endmodule

// File: tb/tb_i2s_pcm_transmitter.sv
module tb_i2s_pcm_transmitter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, pcm_valid;
    logic [11:0] pcm_left, pcm_right;
    logic        pcm_ready, sck, ws, sd, frame_start, underrun;

    logic        enable2, valid2;
    logic [11:0] left2, right2;
    logic        ready2, sck2, ws2, sd2, fs2, ur2;

    i2s_pcm_transmitter #(.NUMBER_OF_BITS(12), .SLOT_BITS(16), .CLK_DIV(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pcm_left(pcm_left), .pcm_right(pcm_right),
        .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .sck(sck), .ws(ws), .sd(sd),
        .frame_start(frame_start), .underrun(underrun));

    i2s_pcm_transmitter #(.NUMBER_OF_BITS(12), .SLOT_BITS(16), .CLK_DIV(1)) dut2 (
        .clk(clk), .reset(reset), .enable(enable2), .pcm_left(left2), .pcm_right(right2),
        .pcm_valid(valid2), .pcm_ready(ready2), .sck(sck2), .ws(ws2), .sd(sd2),
        .frame_start(fs2), .underrun(ur2));

    // Input pair and the 16-bit slot words a receiver must see: {0, sample, 000}.
    typedef struct {
        logic [11:0] l;
        logic [11:0] r;
        logic [15:0] lw;
        logic [15:0] rw;
    } vec_t;
    typedef struct {
        logic [15:0] lw;
        logic [15:0] rw;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ur_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic push_exp(input logic [15:0] lw, input logic [15:0] rw);
        exp_t e;
        e.lw = lw;
        e.rw = rw;
        sb.push_back(e);
    endtask

    // Receiver on dut: samples ws/sd on each sck rise, rebuilds the slot words and
    // checks each completed frame against the scoreboard.
    task automatic monitor();
        logic        prev_sck = 1'b0, prev_sd = 1'b0, last_ws = 1'b1;
        logic [15:0] lw_m = '0, rw_m = '0;
        int          idx = 0, last_fs = 0;
        bit          have_last = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_sck = 1'b0; prev_sd = 1'b0; last_ws = 1'b1; idx = 0; have_last = 0;
            end else begin
                if (sd !== prev_sd) chk("sd_change_on_fall", {30'd0, prev_sck, sck}, 32'd2);
                if (sck && !prev_sck) begin
                    if (ws !== last_ws) idx = 0;
                    else idx++;
                    if (idx < 16) begin
                        if (ws) rw_m[15-idx] = sd;
                        else    lw_m[15-idx] = sd;
                    end
                    last_ws = ws;
                    if (ws && idx == 15) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame: got %0h/%0h expected none", lw_m, rw_m);
                        end else begin
                            e = sb.pop_front();
                            chk("left_slot_word", lw_m, e.lw);
                            chk("right_slot_word", rw_m, e.rw);
                        end
                    end
                end
                if (frame_start) begin
                    if (underrun) ur_total++;
                    else chk("ready_after_load", pcm_ready, 1);
                    if (have_last) chk("frame_period", cyc - last_fs, 128);
                    last_fs = cyc;
                    have_last = 1;
                end
                if (!enable) have_last = 0;
                prev_sck = sck;
                prev_sd = sd;
            end
        end
    endtask

    task automatic send(input vec_t v, input bit keep);
        bit done = 0;
        @(negedge clk);
        pcm_left = v.l;
        pcm_right = v.r;
        pcm_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (pcm_ready) begin
                @(posedge clk);
                push_exp(v.lw, v.rw);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            timeout("send_accept");
            pcm_valid = 1'b0;
        end else begin
            @(negedge clk);
            chk("ready_drop_after_accept", pcm_ready, 0);
            if (!keep) pcm_valid = 1'b0;
        end
    endtask

    task automatic wait_fs(input string name);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1;
        end
        if (!seen) timeout(name);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sck"}, sck, 0);
        chk({tag, "_ws"}, ws, 1);
        chk({tag, "_sd"}, sd, 0);
        chk({tag, "_ready"}, pcm_ready, 1);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_underrun"}, underrun, 0);
    endtask

    initial begin
        int          n, ur_before, nr, last_rise;
        bit          seen;
        logic        prev2;
        logic [15:0] lw2, rw2;

        vecs[0] = '{12'hA5C, 12'h3F1, 16'h52E0, 16'h1F88};
        vecs[1] = '{12'h800, 12'h7FF, 16'h4000, 16'h3FF8};
        vecs[2] = '{12'hFFF, 12'h001, 16'h7FF8, 16'h0008};
        vecs[3] = '{12'h123, 12'hFED, 16'h0918, 16'h7F68};
        vecs[4] = '{12'h555, 12'hAAA, 16'h2AA8, 16'h5550};
        vecs[5] = '{12'h001, 12'hFFF, 16'h0008, 16'h7FF8};
        vecs[6] = '{12'hAAA, 12'h123, 16'h5550, 16'h0918};
        vecs[7] = '{12'hFED, 12'h555, 16'h7F68, 16'h2AA8};

        reset = 1'b1; enable = 1'b0; pcm_valid = 1'b0; pcm_left = '0; pcm_right = '0;
        enable2 = 1'b0; valid2 = 1'b0; left2 = '0; right2 = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // 1: single pair A5C/3F1
        send(vecs[0], 0);
        enable = 1'b1;
        wait_fs("t1_fs");
        chk("t1_no_underrun", underrun, 0);
        enable = 1'b0;
        repeat (140) @(negedge clk);
        chk("t1_sb_drained", sb.size(), 0);

        // 2: enabled with nothing to send -> underrun every frame, silence on sd
        for (int i = 0; i < 3; i++) push_exp(16'h0000, 16'h0000);
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 500 && n < 3; i++) begin
            @(negedge clk);
            if (frame_start) begin
                n++;
                chk("t2_underrun_with_fs", underrun, 1);
                chk("t2_ready_high", pcm_ready, 1);
                if (n == 3) enable = 1'b0;
            end
        end
        if (n < 3) begin
            timeout("t2_frames");
            enable = 1'b0;
        end
        repeat (140) @(negedge clk);
        chk("t2_sb_drained", sb.size(), 0);

        // 3: stream all vectors with pcm_valid held high
        ur_before = ur_total;
        send(vecs[0], 1);
        enable = 1'b1;
        for (int i = 1; i < 8; i++) send(vecs[i], 1);
        pcm_valid = 1'b0;
        wait_fs("t3_last_fs");
        enable = 1'b0;
        repeat (140) @(negedge clk);
        chk("t3_sb_drained", sb.size(), 0);
        chk("t3_no_underrun", ur_total, ur_before);

        // 4: drop enable 40 clk into a frame; the frame still completes
        send(vecs[3], 0);
        enable = 1'b1;
        wait_fs("t4_fs");
        repeat (40) @(negedge clk);
        enable = 1'b0;
        repeat (87) @(negedge clk);
        chk("t4_c127_sck", sck, 1);
        chk("t4_c127_ws", ws, 1);
        @(negedge clk);
        chk("t4_c128_sck", sck, 0);
        chk("t4_c128_ws", ws, 1);
        chk("t4_c128_sd", sd, 0);
        chk("t4_c128_fs", frame_start, 0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_start) n++;
        end
        chk("t4_no_more_fs", n, 0);
        chk("t4_idle_sck", sck, 0);
        chk("t4_idle_ws", ws, 1);
        chk("t4_sb_drained", sb.size(), 0);

        // 5: reset 70 clk into a frame, with another pair held
        send(vecs[4], 0);
        enable = 1'b1;
        wait_fs("t5_fs");
        send(vecs[5], 0);
        repeat (68) @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk_reset_vals("t5_midframe_reset");
        reset = 1'b0;
        sb.delete();
        push_exp(16'h0000, 16'h0000);
        enable = 1'b1;
        wait_fs("t5_fs_after_reset");
        chk("t5_held_pair_discarded", underrun, 1);
        enable = 1'b0;
        repeat (140) @(negedge clk);
        chk("t5_sb_drained", sb.size(), 0);

        // 6: CLK_DIV=1 instance, pair 800/7FF, decoded by a local receiver
        @(negedge clk);
        chk("t6_ready_idle", ready2, 1);
        valid2 = 1'b1; left2 = 12'h800; right2 = 12'h7FF;
        @(negedge clk);
        valid2 = 1'b0;
        chk("t6_ready_drop", ready2, 0);
        enable2 = 1'b1;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (fs2) seen = 1;
        end
        if (!seen) timeout("t6_fs");
        enable2 = 1'b0;
        prev2 = sck2;
        nr = 0; last_rise = 0; lw2 = '0; rw2 = '0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (sck2 && !prev2) begin
                if (nr > 0) chk("t6_sck_period", i - last_rise, 2);
                last_rise = i;
                if (nr < 32) begin
                    chk("t6_ws_slot", ws2, (nr >= 16) ? 1 : 0);
                    if (nr >= 16) rw2[15-(nr-16)] = sd2;
                    else          lw2[15-nr] = sd2;
                end
                nr++;
            end
            prev2 = sck2;
        end
        chk("t6_rise_count", nr, 32);
        chk("t6_left_word", lw2, 16'h4000);
        chk("t6_right_word", rw2, 16'h3FF8);
        chk("t6_left_sample", lw2[14:3], 12'h800);
        chk("t6_right_sample", rw2[14:3], 12'h7FF);
        chk("t6_idle_ws", ws2, 1);

        chk("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
